// File: rtl/bus_fabric_pkg.sv
// Shared types and sizing helpers for the bus fabric and its address decoder.
package bus_fabric_pkg;

  // Transaction phases of the fabric.
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Widest data path a fabric instance may be built with.
  localparam int MAX_DW = 32;
  // Largest number of endpoints one fabric may serve.
  localparam int MAX_EP = 16;
  // Hit counter width; it must hold counts 0..MAX_EP.
  localparam int HIT_CNT_W = 5;
  // Default number of ACCESS cycles allowed before a timeout error.
  localparam int DEF_TIMEOUT = 15;

  // Response as seen by the host: a one-cycle ack, its error flag and read data.
  typedef struct packed {
    logic              ack;
    logic              err;
    logic [MAX_DW-1:0] rdata;
  } resp_t;

  // Width of a counter that must reach the value 'timeout'.
  function automatic int to_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// Host-side and endpoint-side signals of the native parallel bus fabric.
// 'slave' is the fabric's own view; 'master' is the view of whoever drives
// the host request and the endpoint responses.
interface bus_fabric_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int N_EP       = 2
);
  logic                       h_req;
  logic                       h_r_wn;
  logic [ADDR_WIDTH-1:0]      h_addr;
  logic [DATA_WIDTH-1:0]      h_wdata;
  logic                       busy;
  logic                       h_ack;
  logic                       h_err;
  logic [DATA_WIDTH-1:0]      h_rdata;
  logic [N_EP-1:0]            ep_sel;
  logic                       ep_r_wn;
  logic [ADDR_WIDTH-1:0]      ep_addr;
  logic [DATA_WIDTH-1:0]      ep_wdata;
  logic [N_EP-1:0]            ep_ack;
  logic [N_EP*DATA_WIDTH-1:0] ep_rdata;

  modport slave (
    input  h_req, h_r_wn, h_addr, h_wdata, ep_ack, ep_rdata,
    output busy, h_ack, h_err, h_rdata, ep_sel, ep_r_wn, ep_addr, ep_wdata
  );

  modport master (
    output h_req, h_r_wn, h_addr, h_wdata, ep_ack, ep_rdata,
    input  busy, h_ack, h_err, h_rdata, ep_sel, ep_r_wn, ep_addr, ep_wdata
  );
endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: which endpoint windows contain addr,
// how many of them do, and the window-relative offset for a single hit.
module bus_addr_decode
  import bus_fabric_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int N_EP       = 2,
  parameter int BASE  [N_EP] = '{0, 32},
  parameter int RANGE [N_EP] = '{8, 128}
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [N_EP-1:0]       hit,
  output logic [HIT_CNT_W-1:0]  hit_cnt,
  output logic [ADDR_WIDTH-1:0] offset
);

  // One extra bit so a window ending exactly at 2^ADDR_WIDTH is representable.
  localparam int AW1 = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] off_term [N_EP];

  genvar gi;
  generate
    for (gi = 0; gi < N_EP; gi++) begin : g_win
      localparam logic [ADDR_WIDTH:0] LO = AW1'(BASE[gi]);
      localparam logic [ADDR_WIDTH:0] HI = AW1'(BASE[gi] + RANGE[gi]);

      if (BASE[gi] < 0 || RANGE[gi] < 0 || BASE[gi] + RANGE[gi] > (1 << ADDR_WIDTH)) begin : g_bad_window
        $error("bus_addr_decode: endpoint window exceeds the address space");
      end

      assign hit[gi]      = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
      // Subtraction wraps modulo 2^ADDR_WIDTH, which is exact inside a legal window.
      assign off_term[gi] = hit[gi] ? (addr - LO[ADDR_WIDTH-1:0]) : '0;
    end
  endgenerate

  // Count hits and merge offsets; the merged offset is only meaningful for one hit.
  always_comb begin
    hit_cnt = '0;
    offset  = '0;
    for (int i = 0; i < N_EP; i++) begin
      hit_cnt = hit_cnt + HIT_CNT_W'(hit[i]);
      offset  = offset | off_term[i];
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Clocked one-host, N-endpoint interconnect. Latches each accepted request,
// selects the single endpoint whose window holds the address, waits for its
// ack (bounded by TIMEOUT) and returns a one-cycle registered response.
// Unmapped or ambiguous addresses and silent endpoints answer with h_err.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int N_EP       = 2,
  parameter int BASE  [N_EP] = '{0, 32},
  parameter int RANGE [N_EP] = '{8, 128},
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  bus_fabric_if.slave bus
);

  localparam int CNT_W = to_cnt_width(TIMEOUT);

  generate
    if (N_EP < 1 || N_EP > MAX_EP) begin : g_bad_n_ep
      $error("bus_fabric: N_EP must be within 1..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("bus_fabric: TIMEOUT must be at least 1");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_DW) begin : g_bad_dw
      $error("bus_fabric: DATA_WIDTH outside the supported range");
    end
  endgenerate

  state_t                state_reg;
  logic                  busy_reg;
  resp_t                 resp_reg;
  logic [N_EP-1:0]       ep_sel_reg;
  logic                  ep_r_wn_reg;
  logic [ADDR_WIDTH-1:0] ep_addr_reg;
  logic [DATA_WIDTH-1:0] ep_wdata_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic [N_EP-1:0]       dec_hit;
  logic [HIT_CNT_W-1:0]  dec_hit_cnt;
  logic [ADDR_WIDTH-1:0] dec_offset;
  logic [DATA_WIDTH-1:0] rd_term [N_EP];
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_ack;
  logic                  unused_rdata_bits;

  bus_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_EP       (N_EP),
    .BASE       (BASE),
    .RANGE      (RANGE)
  ) u_decode (
    .addr    (bus.h_addr),
    .hit     (dec_hit),
    .hit_cnt (dec_hit_cnt),
    .offset  (dec_offset)
  );

  // Per-endpoint read data gated by the registered select.
  genvar gi;
  generate
    for (gi = 0; gi < N_EP; gi++) begin : g_rd
      assign rd_term[gi] = ep_sel_reg[gi] ? bus.ep_rdata[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  // OR the gated terms together; at most one is non-zero because ep_sel is one-hot.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_EP; i++) begin
      sel_rdata = sel_rdata | rd_term[i];
    end
  end

  // Only the selected endpoint's ack counts; others are ignored.
  assign sel_ack = |(bus.ep_ack & ep_sel_reg);

  // Transaction FSM with all host- and endpoint-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      resp_reg     <= '0;
      ep_sel_reg   <= '0;
      ep_r_wn_reg  <= 1'b1;
      ep_addr_reg  <= '0;
      ep_wdata_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.h_req) begin
            busy_reg     <= 1'b1;
            ep_r_wn_reg  <= bus.h_r_wn;
            ep_addr_reg  <= dec_offset;
            ep_wdata_reg <= bus.h_wdata;
            if (dec_hit_cnt == HIT_CNT_W'(1)) begin
              state_reg  <= ACCESS;
              ep_sel_reg <= dec_hit;
              cnt_reg    <= CNT_W'(1);
            end else begin
              // No endpoint or several endpoints claim the address.
              state_reg      <= RESP;
              resp_reg.ack   <= 1'b1;
              resp_reg.err   <= 1'b1;
              resp_reg.rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            // An ack arriving together with the last allowed cycle still wins.
            state_reg      <= RESP;
            ep_sel_reg     <= '0;
            cnt_reg        <= '0;
            resp_reg.ack   <= 1'b1;
            resp_reg.err   <= 1'b0;
            resp_reg.rdata <= ep_r_wn_reg ? MAX_DW'(sel_rdata) : '0;
          end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
            state_reg      <= RESP;
            ep_sel_reg     <= '0;
            cnt_reg        <= '0;
            resp_reg.ack   <= 1'b1;
            resp_reg.err   <= 1'b1;
            resp_reg.rdata <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESP: begin
          // Response lasts exactly one cycle and releases busy with it.
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          resp_reg  <= '0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          resp_reg  <= '0;
        end
      endcase
    end
  end

  // Upper response bits beyond DATA_WIDTH are always zero.
  assign unused_rdata_bits = ^{1'b0, resp_reg.rdata};

  assign bus.busy     = busy_reg;
  assign bus.h_ack    = resp_reg.ack;
  assign bus.h_err    = resp_reg.err;
  assign bus.h_rdata  = resp_reg.rdata[DATA_WIDTH-1:0];
  assign bus.ep_sel   = ep_sel_reg;
  assign bus.ep_r_wn  = ep_r_wn_reg;
  assign bus.ep_addr  = ep_addr_reg;
  assign bus.ep_wdata = ep_wdata_reg;

endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: reset state, a table of directed transactions,
// a reset-abort sequence and random transactions against a window model.
module tb_bus_fabric;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bus_fabric_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .N_EP(2)) bus_if ();

  bus_fabric #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .N_EP       (2),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int errors = 0;
  int checks = 0;

  // Endpoint windows as the system map defines them.
  int m_base  [2] = '{0, 32};
  int m_range [2] = '{8, 128};

  typedef struct {
    bit         r_wn;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         delay;      // ACCESS cycles before the endpoint acks (large = silent)
    logic [7:0] rd0;
    logic [7:0] rd1;
    bit         noise;      // stray h_req and non-selected ep_ack while busy
    bit         exp_err;
    int         exp_lat;    // cycles from accepting edge to the h_ack cycle
    logic [1:0] exp_sel;
    logic [7:0] exp_addr;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count windows containing addr, then apply ack/timeout rules.
  function automatic void model(input bit r_wn, input int addr, input int delay,
                                input logic [7:0] rd0, input logic [7:0] rd1,
                                output bit e, output int lat, output logic [1:0] sel,
                                output logic [7:0] off, output logic [7:0] rd);
    int n;
    int idx;
    n = 0;
    idx = 0;
    sel = 2'b00;
    off = 8'h00;
    rd  = 8'h00;
    for (int i = 0; i < 2; i++) begin
      if (addr >= m_base[i] && addr < m_base[i] + m_range[i]) begin
        n++;
        idx = i;
      end
    end
    if (n != 1) begin
      e = 1'b1;
      lat = 1;
      return;
    end
    sel = (idx == 1) ? 2'b10 : 2'b01;
    off = 8'(addr - m_base[idx]);
    if (delay < TO) begin
      e = 1'b0;
      lat = delay + 2;
      rd = r_wn ? ((idx == 1) ? rd1 : rd0) : 8'h00;
    end else begin
      e = 1'b1;
      lat = TO + 1;
    end
  endfunction

  task automatic run_txn(input int id, input vec_t v);
    int         lat;
    int         idx;
    bit         got_err;
    logic [7:0] got_rd;
    bit         stray;
    bit         busy_ok;
    idx = v.exp_sel[1] ? 1 : 0;
    lat = 0;
    got_err = 1'b0;
    got_rd = 8'h00;
    stray = 1'b0;
    busy_ok = 1'b1;
    @(negedge clk);
    bus_if.h_req    = 1'b1;
    bus_if.h_r_wn   = v.r_wn;
    bus_if.h_addr   = v.addr;
    bus_if.h_wdata  = v.wdata;
    bus_if.ep_rdata = {v.rd1, v.rd0};
    bus_if.ep_ack   = 2'b00;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("ep_sel[%0d]", id), 32'(bus_if.ep_sel), 32'(v.exp_sel));
        if (v.exp_sel != 2'b00) begin
          chk($sformatf("ep_addr[%0d]", id), 32'(bus_if.ep_addr), 32'(v.exp_addr));
          chk($sformatf("ep_r_wn[%0d]", id), 32'(bus_if.ep_r_wn), 32'(v.r_wn));
          chk($sformatf("ep_wdata[%0d]", id), 32'(bus_if.ep_wdata), 32'(v.wdata));
        end
      end
      if (bus_if.h_err && !bus_if.h_ack) stray = 1'b1;
      if (!bus_if.busy) busy_ok = 1'b0;
      if (bus_if.h_ack) begin
        lat = k;
        got_err = bus_if.h_err;
        got_rd = bus_if.h_rdata;
      end
      bus_if.ep_ack = 2'b00;
      if (v.exp_sel != 2'b00 && k - 1 == v.delay) bus_if.ep_ack[idx] = 1'b1;
      if (v.noise) begin
        bus_if.ep_ack[1-idx] = 1'($urandom_range(0, 1));
        bus_if.h_req   = 1'b1;
        bus_if.h_r_wn  = 1'($urandom_range(0, 1));
        bus_if.h_addr  = 8'($urandom_range(0, 255));
        bus_if.h_wdata = 8'($urandom_range(0, 255));
      end else begin
        bus_if.h_req = 1'b0;
      end
    end
    if (lat == 0) begin
      errors++;
      checks++;
      $display("FAIL ack_timeout[%0d]: got no h_ack within 40 cycles expected h_ack", id);
    end else begin
      chk($sformatf("latency[%0d]", id), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("h_err[%0d]", id), 32'(got_err), 32'(v.exp_err));
      chk($sformatf("h_rdata[%0d]", id), 32'(got_rd), 32'(v.exp_rdata));
    end
    chk($sformatf("stray_err[%0d]", id), 32'(stray), 32'(0));
    chk($sformatf("busy_held[%0d]", id), 32'(busy_ok), 32'(1));
    @(negedge clk);
    chk($sformatf("busy_after[%0d]", id), 32'(bus_if.busy), 32'(0));
    chk($sformatf("ack_after[%0d]", id), 32'(bus_if.h_ack), 32'(0));
    bus_if.h_req  = 1'b0;
    bus_if.ep_ack = 2'b00;
    $display("txn %0d: %s addr=%02h lat=%0d err=%0d rdata=%02h", id,
             v.r_wn ? "RD" : "WR", v.addr, lat, got_err, got_rd);
  endtask

  initial begin
    vec_t       rv;
    int         acks_seen;
    bus_if.h_req    = 1'b0;
    bus_if.h_r_wn   = 1'b0;
    bus_if.h_addr   = 8'h00;
    bus_if.h_wdata  = 8'h00;
    bus_if.ep_ack   = 2'b00;
    bus_if.ep_rdata = 16'h0000;

    //          r_wn addr   wdata  dly rd0    rd1    nz err lat sel    eaddr  erdata
    vecs[0] = '{1'b0, 8'h03, 8'h5A, 0,  8'h00, 8'h00, 0, 0, 2,  2'b01, 8'h03, 8'h00};
    vecs[1] = '{1'b1, 8'h25, 8'h00, 3,  8'h00, 8'hC3, 0, 0, 5,  2'b10, 8'h05, 8'hC3};
    vecs[2] = '{1'b1, 8'h10, 8'h00, 0,  8'h12, 8'h34, 0, 1, 1,  2'b00, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 8'h20, 8'h00, 99, 8'h55, 8'h66, 0, 1, 16, 2'b10, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 8'h07, 8'h00, 14, 8'h11, 8'h22, 0, 0, 16, 2'b01, 8'h07, 8'h11};
    vecs[5] = '{1'b1, 8'h9F, 8'h00, 1,  8'h33, 8'h77, 1, 0, 3,  2'b10, 8'h7F, 8'h77};
    vecs[6] = '{1'b0, 8'hA0, 8'hEE, 0,  8'h01, 8'h02, 1, 1, 1,  2'b00, 8'h00, 8'h00};
    vecs[7] = '{1'b0, 8'h00, 8'hFF, 2,  8'hAB, 8'hCD, 1, 0, 4,  2'b01, 8'h00, 8'h00};
    vecs[8] = '{1'b1, 8'h20, 8'h00, 15, 8'h44, 8'h99, 0, 1, 16, 2'b10, 8'h00, 8'h00};
    vecs[9] = '{1'b1, 8'h08, 8'h00, 0,  8'h5E, 8'h6F, 0, 1, 1,  2'b00, 8'h00, 8'h00};

    // Reset state, sampled while reset is still held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",     32'(bus_if.busy),     32'(0));
    chk("rst_h_ack",    32'(bus_if.h_ack),    32'(0));
    chk("rst_h_err",    32'(bus_if.h_err),    32'(0));
    chk("rst_h_rdata",  32'(bus_if.h_rdata),  32'(0));
    chk("rst_ep_sel",   32'(bus_if.ep_sel),   32'(0));
    chk("rst_ep_r_wn",  32'(bus_if.ep_r_wn),  32'(1));
    chk("rst_ep_addr",  32'(bus_if.ep_addr),  32'(0));
    chk("rst_ep_wdata", 32'(bus_if.ep_wdata), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

    // Reset during ACCESS aborts the transaction without any h_ack.
    @(negedge clk);
    bus_if.h_req    = 1'b1;
    bus_if.h_r_wn   = 1'b1;
    bus_if.h_addr   = 8'h25;
    bus_if.ep_rdata = 16'h4400;
    @(negedge clk);
    bus_if.h_req = 1'b0;
    chk("abort_pre_sel", 32'(bus_if.ep_sel), 32'(2));
    rst = 1'b1;
    bus_if.ep_ack = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    bus_if.ep_ack = 2'b00;
    chk("abort_busy",   32'(bus_if.busy),   32'(0));
    chk("abort_ep_sel", 32'(bus_if.ep_sel), 32'(0));
    acks_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus_if.h_ack) acks_seen++;
      @(negedge clk);
    end
    chk("abort_no_ack", 32'(acks_seen), 32'(0));
    $display("txn abort: reset in ACCESS, acks_seen=%0d", acks_seen);
    run_txn(10, vecs[1]);

    // Random transactions against the window model.
    for (int i = 0; i < 40; i++) begin
      rv.r_wn  = 1'($urandom_range(0, 1));
      rv.addr  = 8'($urandom_range(0, 255));
      rv.wdata = 8'($urandom_range(0, 255));
      rv.delay = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 4));
      rv.rd0   = 8'($urandom_range(0, 255));
      rv.rd1   = 8'($urandom_range(0, 255));
      rv.noise = 1'($urandom_range(0, 1));
      model(rv.r_wn, int'(rv.addr), rv.delay, rv.rd0, rv.rd1,
            rv.exp_err, rv.exp_lat, rv.exp_sel, rv.exp_addr, rv.exp_rdata);
      run_txn(100 + i, rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
